multicore_arbiter_n: RTL

Parametrised shared-resource arbiter for the N-core multicore top. It generalises the fixed three-requester arbiter to NUM_CORES requesters and adds a selectable round-robin or fixed-priority policy. It also adds direct grant hand-off and a maximum-hold pre-emption timer. It sits between the cpu instances' req_arb/gnt_arb pins and replaces the fixed arbiter when the core count is a parameter.

---
 rtl/multicore_arbiter_n_pkg.sv | 11 +
 rtl/multicore_arbiter_n_rr_select.sv | 40 ++++
 rtl/multicore_arbiter_n.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/multicore_arbiter_n_pkg.sv
// Shared types and defaults for the parametrised multicore arbiter.
// Imported by the arbiter top and its selection sub-module.
package multicore_arbiter_n_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;

    typedef enum logic [1:0] {IDLE, GRANT, PREEMPT} arb_state_t;

    localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/multicore_arbiter_n_rr_select.sv
// Combinational next-holder picker: round-robin scan starting after `last`,
// or lowest-index-first, over requests that are not masked by `excl`.
module multicore_arbiter_n_rr_select
    import multicore_arbiter_n_pkg::*;
#(
    parameter int NUM_CORES = 3,
    localparam int IDW = $clog2(NUM_CORES)
) (
    input  arb_mode_t              mode,
    input  logic [NUM_CORES-1:0]   req,
    input  logic [NUM_CORES-1:0]   excl,
    input  logic [IDW-1:0]         last,
    output logic [IDW-1:0]         idx,
    output logic                   found
);

    logic [NUM_CORES-1:0] cand;
    int                   start;
    int                   j;

    always_comb begin
        cand  = req & ~excl;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // start never exceeds NUM_CORES, so one subtraction wraps the scan
        start = (mode == ARB_RR) ? int'(last) + 1 : 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            j = start + i;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (!found && cand[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/multicore_arbiter_n.sv
// Shared-resource arbiter for NUM_CORES requesters: round-robin or fixed
// priority, direct hand-off on release, and max-hold pre-emption.
module multicore_arbiter_n
    import multicore_arbiter_n_pkg::*;
#(
    parameter int        NUM_CORES = 3,
    parameter arb_mode_t MODE      = ARB_RR,
    parameter int        MAX_HOLD  = DEF_MAX_HOLD,
    localparam int       IDW       = $clog2(NUM_CORES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_arb [NUM_CORES-1:0],
    output logic           gnt_arb [NUM_CORES-1:0],
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    localparam int CNTW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    // The counter stops at the pre-emption threshold so a long-running lone
    // holder is pre-empted as soon as a competitor shows up.
    localparam logic [CNTW-1:0] CNT_TOP = (MAX_HOLD > 0) ? CNTW'(MAX_HOLD - 1) : '0;

    arb_state_t           state_reg, state_next;
    logic [IDW-1:0]       h_reg, h_next;
    logic [IDW-1:0]       last_reg, last_next;
    logic [CNTW-1:0]      cnt_reg, cnt_next, cnt_inc;
    logic [NUM_CORES-1:0] gnt_reg, gnt_next;
    logic                 preempt_reg, preempt_next;

    logic [NUM_CORES-1:0] req_vec;
    logic [NUM_CORES-1:0] h_mask;
    logic [NUM_CORES-1:0] excl;
    logic [NUM_CORES-1:0] sel_onehot;
    logic [IDW-1:0]       sel_idx;
    logic                 sel_found;
    logic                 hold_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign req_vec[gi] = req_arb[gi];
            assign h_mask[gi]  = (h_reg == IDW'(gi));
            assign gnt_arb[gi] = gnt_reg[gi];
        end
    endgenerate

    // Outside IDLE the current (or just pre-empted) holder is never a candidate.
    assign excl       = (state_reg == IDLE) ? '0 : h_mask;
    assign hold_req   = |(req_vec & h_mask);
    assign sel_onehot = NUM_CORES'(1) << sel_idx;
    assign cnt_inc    = (cnt_reg == CNT_TOP) ? cnt_reg : cnt_reg + CNTW'(1);

    multicore_arbiter_n_rr_select #(
        .NUM_CORES (NUM_CORES)
    ) u_sel (
        .mode  (MODE),
        .req   (req_vec),
        .excl  (excl),
        .last  (last_reg),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_comb begin
        state_next   = state_reg;
        h_next       = h_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        preempt_next = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt_next = '0;
                if (sel_found) begin
                    state_next = GRANT;
                    h_next     = sel_idx;
                    last_next  = sel_idx;
                    cnt_next   = '0;
                    gnt_next   = sel_onehot;
                end
            end
            GRANT: begin
                cnt_next = cnt_inc;
                if (!hold_req) begin
                    if (sel_found) begin
                        h_next    = sel_idx;
                        last_next = sel_idx;
                        cnt_next  = '0;
                        gnt_next  = sel_onehot;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else if (MAX_HOLD != 0 && cnt_reg == CNT_TOP && sel_found) begin
                    state_next   = PREEMPT;
                    gnt_next     = '0;
                    preempt_next = 1'b1;
                end
            end
            PREEMPT: begin
                cnt_next = '0;
                if (sel_found) begin
                    state_next = GRANT;
                    h_next     = sel_idx;
                    last_next  = sel_idx;
                    gnt_next   = sel_onehot;
                end else if (hold_req) begin
                    state_next = GRANT;
                    last_next  = h_reg;
                    gnt_next   = h_mask;
                end else begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            h_reg       <= '0;
            last_reg    <= IDW'(NUM_CORES - 1);
            cnt_reg     <= '0;
            gnt_reg     <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            h_reg       <= h_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            preempt_reg <= preempt_next;
        end
    end

    assign busy    = |gnt_reg;
    assign gnt_id  = h_reg;
    assign preempt = preempt_reg;

endmodule
